// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit architectural register file with per-register
// rename state (busy flag plus ROB tag). The decoder reads source operands
// and renames destinations here. The ROB retires register writes through
// the commit_reg_* inputs. A rollback discards all speculative rename
// state and keeps the architectural values.
module reg_file #(
  parameter int REG_NUM   = 32,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  // ROB retirement
  input  logic                 commit_reg_config,
  input  logic [4:0]           commit_reg_id,
  input  logic [DATA_W-1:0]    commit_reg_value,
  input  logic [ROB_IDX_W-1:0] commit_reg_rob,
  // decoder destination rename
  input  logic                 rename_config,
  input  logic [4:0]           rename_rd,
  input  logic [ROB_IDX_W-1:0] rename_rob,
  // source read port 1
  input  logic [4:0]           rs1_id,
  output logic [DATA_W-1:0]    rs1_value,
  output logic                 rs1_busy,
  output logic [ROB_IDX_W-1:0] rs1_rob_tag,
  // source read port 2
  input  logic [4:0]           rs2_id,
  output logic [DATA_W-1:0]    rs2_value,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs2_rob_tag
);

  localparam int IDX_W = 5;
  localparam int RD_W  = DATA_W + 1 + ROB_IDX_W;

  // Per-register architectural value and rename state.
  logic [DATA_W-1:0]    r_value [REG_NUM];
  logic [REG_NUM-1:0]   r_busy;
  logic [ROB_IDX_W-1:0] r_tag   [REG_NUM];

  logic w_commit_en;
  logic w_commit_hit;
  logic w_rename_en;
  logic w_flush;

  // A commit to x0 is dropped. A commit only clears busy when its ROB
  // entry is still the register's current producer. A younger rename
  // keeps ownership otherwise.
  assign w_commit_en  = rdy && commit_reg_config && (commit_reg_id != '0);
  assign w_commit_hit = w_commit_en && r_busy[commit_reg_id] &&
                        (r_tag[commit_reg_id] == commit_reg_rob);
  // A rename in a rollback cycle belongs to the squashed path.
  assign w_rename_en  = rdy && rename_config && (rename_rd != '0) && !rollback;
  assign w_flush      = rdy && rollback;

  // Resolve one read port. A same-cycle retirement of the current producer
  // is forwarded as a ready value. A same-cycle rename is never visible,
  // because the decoder reads its sources before renaming its own rd.
  function automatic logic [RD_W-1:0] resolve_read(
    input logic [IDX_W-1:0]     id,
    input logic [DATA_W-1:0]    stored_val,
    input logic                 stored_busy,
    input logic [ROB_IDX_W-1:0] stored_tag,
    input logic                 commit_en,
    input logic [IDX_W-1:0]     commit_id,
    input logic [DATA_W-1:0]    commit_val,
    input logic [ROB_IDX_W-1:0] commit_rob
  );
    logic [RD_W-1:0] res;
    logic            hit;
    hit = commit_en && (commit_id == id) && stored_busy &&
          (stored_tag == commit_rob);
    if (id == '0) begin
      res = '0;
    end else if (hit) begin
      res = {commit_val, 1'b0, stored_tag};
    end else begin
      res = {stored_val, stored_busy, stored_tag};
    end
    return res;
  endfunction

  // Register state update: commit writes the value, rollback clears every
  // busy flag, and a rename takes precedence over a same-cycle retirement
  // of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
      r_busy <= '0;
    end else if (rdy) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (w_commit_en && (commit_reg_id == IDX_W'(i))) begin
          r_value[i] <= commit_reg_value;
        end
        if (w_flush) begin
          r_busy[i] <= 1'b0;
        end else if (w_rename_en && (rename_rd == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_tag[i]  <= rename_rob;
        end else if (w_commit_hit && (commit_reg_id == IDX_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Read port 1: combinational from stored state plus commit bypass.
  always_comb begin
    {rs1_value, rs1_busy, rs1_rob_tag} = resolve_read(
      rs1_id, r_value[rs1_id], r_busy[rs1_id], r_tag[rs1_id],
      w_commit_en, commit_reg_id, commit_reg_value, commit_reg_rob);
  end

  // Read port 2: combinational from stored state plus commit bypass.
  always_comb begin
    {rs2_value, rs2_busy, rs2_rob_tag} = resolve_read(
      rs2_id, r_value[rs2_id], r_busy[rs2_id], r_tag[rs2_id],
      w_commit_en, commit_reg_id, commit_reg_value, commit_reg_rob);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file. A driver issues one
// transaction per cycle and pushes the predicted read results. A separate
// monitor pops the predictions and compares them with the DUT read ports.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        rollback;
  logic        commit_reg_config;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_reg_value;
  logic [3:0]  commit_reg_rob;
  logic        rename_config;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_rob;
  logic [4:0]  rs1_id;
  logic [31:0] rs1_value;
  logic        rs1_busy;
  logic [3:0]  rs1_rob_tag;
  logic [4:0]  rs2_id;
  logic [31:0] rs2_value;
  logic        rs2_busy;
  logic [3:0]  rs2_rob_tag;

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .commit_reg_config(commit_reg_config), .commit_reg_id(commit_reg_id),
    .commit_reg_value(commit_reg_value), .commit_reg_rob(commit_reg_rob),
    .rename_config(rename_config), .rename_rd(rename_rd), .rename_rob(rename_rob),
    .rs1_id(rs1_id), .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_rob_tag(rs1_rob_tag),
    .rs2_id(rs2_id), .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_rob_tag(rs2_rob_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  typedef struct {
    int          port;
    logic [31:0] v;
    logic        b;
    logic [3:0]  t;
  } exp_t;

  exp_t q[$];
  event mon_ev;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  // Prediction of a read port from the model and the current input drive.
  function automatic exp_t predict(input logic [4:0] id, input int port);
    exp_t e;
    e.port = port;
    if (id == 5'd0) begin
      e.v = 32'h0; e.b = 1'b0; e.t = 4'h0;
    end else if (rst_n && rdy && commit_reg_config && commit_reg_id == id &&
                 m_busy[id] && m_tag[id] == commit_reg_rob) begin
      e.v = commit_reg_value; e.b = 1'b0; e.t = m_tag[id];
    end else begin
      e.v = m_val[id]; e.b = m_busy[id]; e.t = m_tag[id];
    end
    return e;
  endfunction

  // Advance the model by one clock edge under the current input drive.
  task automatic model_edge();
    logic retire;
    if (!rst_n || !rdy) return;
    retire = 1'b0;
    if (commit_reg_config && commit_reg_id != 5'd0) begin
      retire = m_busy[commit_reg_id] && (m_tag[commit_reg_id] == commit_reg_rob);
      m_val[commit_reg_id] = commit_reg_value;
    end
    if (retire) m_busy[commit_reg_id] = 1'b0;
    if (rollback) begin
      for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
    end else if (rename_config && rename_rd != 5'd0) begin
      m_busy[rename_rd] = 1'b1;
      m_tag[rename_rd]  = rename_rob;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 32; k++) begin
      m_val[k] = 32'h0; m_busy[k] = 1'b0; m_tag[k] = 4'h0;
    end
  endtask

  task automatic step(input logic i_rdy, input logic i_rb,
                      input logic i_cc, input logic [4:0] i_cid,
                      input logic [31:0] i_cval, input logic [3:0] i_crob,
                      input logic i_rc, input logic [4:0] i_rrd, input logic [3:0] i_rrob,
                      input logic [4:0] i_r1, input logic [4:0] i_r2);
    @(negedge clk);
    rdy = i_rdy; rollback = i_rb;
    commit_reg_config = i_cc; commit_reg_id = i_cid;
    commit_reg_value = i_cval; commit_reg_rob = i_crob;
    rename_config = i_rc; rename_rd = i_rrd; rename_rob = i_rrob;
    rs1_id = i_r1; rs2_id = i_r2;
    #1;
    q.push_back(predict(i_r1, 1));
    q.push_back(predict(i_r2, 2));
    ->mon_ev;
    model_edge();
  endtask

  task automatic idle_read(input logic [4:0] a, input logic [4:0] b);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 4'h0, a, b);
  endtask

  // Assert reset between edges and check the reads before the next edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rdy = 1'b1; rollback = 1'b0; commit_reg_config = 1'b0; rename_config = 1'b0;
    rs1_id = 5'd5; rs2_id = 5'($urandom_range(0, 31));
    model_clear();
    #1;
    q.push_back(predict(rs1_id, 1));
    q.push_back(predict(rs2_id, 2));
    ->mon_ev;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT read ports with queued predictions.
  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      #1;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL qempty at %0t: got 0 entries expected 2", $time);
      end
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.port == 1) begin
          chk("rs1_value", rs1_value, e.v);
          chk("rs1_busy", {31'h0, rs1_busy}, {31'h0, e.b});
          chk("rs1_tag", {28'h0, rs1_rob_tag}, {28'h0, e.t});
        end else begin
          chk("rs2_value", rs2_value, e.v);
          chk("rs2_busy", {31'h0, rs2_busy}, {31'h0, e.b});
          chk("rs2_tag", {28'h0, rs2_rob_tag}, {28'h0, e.t});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] cid, rrd, r1, r2;
    logic [3:0] crob;
    rst_n = 1'b0; rdy = 1'b0; rollback = 1'b0;
    commit_reg_config = 1'b0; commit_reg_id = '0; commit_reg_value = '0; commit_reg_rob = '0;
    rename_config = 1'b0; rename_rd = '0; rename_rob = '0; rs1_id = '0; rs2_id = '0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Rename then commit with bypass.
    step(1, 0, 0, 0, 32'h0, 0, 1, 5, 3, 5, 0);
    idle_read(5, 0);
    step(1, 0, 1, 5, 32'hDEADBEEF, 3, 0, 0, 0, 5, 5);
    idle_read(5, 0);
    // Stale commit after a re-rename.
    step(1, 0, 0, 0, 32'h0, 0, 1, 7, 2, 7, 0);
    step(1, 0, 0, 0, 32'h0, 0, 1, 7, 9, 7, 0);
    step(1, 0, 1, 7, 32'h11, 2, 0, 0, 0, 7, 0);
    step(1, 0, 1, 7, 32'h22, 9, 0, 0, 0, 7, 7);
    idle_read(7, 0);
    // Same-cycle commit and rename on x4.
    step(1, 0, 0, 0, 32'h0, 0, 1, 4, 1, 4, 0);
    step(1, 0, 1, 4, 32'h55, 1, 1, 4, 6, 4, 4);
    idle_read(4, 0);
    // Rollback with a simultaneous rename and commit.
    step(1, 0, 0, 0, 32'h0, 0, 1, 3, 1, 3, 0);
    step(1, 0, 0, 0, 32'h0, 0, 1, 8, 2, 8, 3);
    step(1, 0, 0, 0, 32'h0, 0, 1, 10, 3, 10, 8);
    step(1, 1, 1, 3, 32'h77, 1, 1, 12, 4, 3, 12);
    idle_read(3, 12);
    idle_read(8, 10);
    // x0 is never written or busy; rdy low freezes state.
    step(1, 0, 1, 0, 32'hFFFFFFFF, 0, 1, 0, 5, 0, 0);
    idle_read(0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 1, 9, 7, 9, 0);
    step(0, 0, 1, 5, 32'hABCD0123, 0, 0, 0, 0, 5, 9);
    idle_read(9, 5);
    // Reset mid-run after writes.
    do_reset();
    idle_read(5, 7);

    // Randomized traffic concentrated on a few registers to force collisions.
    for (int n = 0; n < 3000; n++) begin
      cid  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rrd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      crob = ($urandom_range(0, 1) == 0) ? m_tag[cid] : 4'($urandom_range(0, 15));
      r1   = ($urandom_range(0, 1) == 0) ? cid : 5'($urandom_range(0, 7));
      r2   = ($urandom_range(0, 2) == 0) ? rrd : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)), cid, $urandom, crob,
           1'($urandom_range(0, 1)), rrd, 4'($urandom_range(0, 15)), r1, r2);
      if (n == 1500) do_reset();
    end

    @(negedge clk);
    #4;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d entries expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
